// File: rtl/cnn_pkg.sv
// Shared conv2d constants, width helpers and the sequencer state type.
package cnn_pkg;

    localparam int IMG_W       = 8;
    localparam int IMG_H       = 8;
    localparam int K           = 3;
    localparam int NUM_FILTERS = 2;

    // Widths never collapse to zero so single-value counters stay legal.
    function automatic int clogMin1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int addrWidth(input int w, input int h);
        return clogMin1(w * h);
    endfunction

    function automatic int wtWidth(input int nf, input int k);
        return clogMin1(nf * k * k);
    endfunction

    function automatic int filtWidth(input int nf);
        return clogMin1(nf);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DONE
    } seqState_e;

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Combinational window-coordinate to image-buffer address mapping.
// All padding decisions for "same" convolution (CONV_SEQ_PAD_EN) live here.
module conv_tap_addr_gen #(
    parameter  int IMG_W = cnn_pkg::IMG_W,
    parameter  int IMG_H = cnn_pkg::IMG_H,
    parameter  int XW    = 3,
    parameter  int YW    = 3,
    parameter  int KW    = 2,
    parameter  int HALF  = 0,
    localparam int AW    = cnn_pkg::addrWidth(IMG_W, IMG_H)
) (
    input  logic [XW-1:0] ox_i,
    input  logic [YW-1:0] oy_i,
    input  logic [KW-1:0] kx_i,
    input  logic [KW-1:0] ky_i,
    output logic [AW-1:0] rd_addr_o,
    output logic          tap_pad_o
);

    int px;
    int py;

    // Signed pixel coordinates so a window hanging off the top/left edge goes negative.
    always_comb begin
        px        = int'(ox_i) + int'(kx_i) - HALF;
        py        = int'(oy_i) + int'(ky_i) - HALF;
        rd_addr_o = '0;
        tap_pad_o = 1'b0;
`ifdef CONV_SEQ_PAD_EN
        if (px < 0 || px >= IMG_W || py < 0 || py >= IMG_H) begin
            tap_pad_o = 1'b1;
        end else begin
            rd_addr_o = AW'(py * IMG_W + px);
        end
`else
        rd_addr_o = AW'(py * IMG_W + px);
`endif
    end

endmodule

// File: rtl/conv_sequencer.sv
// Conv2d control FSM: loads one frame, then issues one kernel tap per cycle.
// Define CONV_SEQ_PAD_EN for "same" convolution; default build is valid-mode.
module conv_sequencer #(
    parameter  int IMG_W       = cnn_pkg::IMG_W,
    parameter  int IMG_H       = cnn_pkg::IMG_H,
    parameter  int K           = cnn_pkg::K,
    parameter  int NUM_FILTERS = cnn_pkg::NUM_FILTERS,
    localparam int AW          = cnn_pkg::addrWidth(IMG_W, IMG_H),
    localparam int WW          = cnn_pkg::wtWidth(NUM_FILTERS, K),
    localparam int FW          = cnn_pkg::filtWidth(NUM_FILTERS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    output logic          pix_wr_en_o,
    output logic [AW-1:0] pix_wr_addr_o,
    input  logic          stall_i,
    output logic          tap_valid_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [WW-1:0] wt_addr_o,
    output logic          tap_pad_o,
    output logic          acc_clr_o,
    output logic          acc_last_o,
    output logic [FW-1:0] filt_idx_o,
    output logic [AW-1:0] pos_idx_o,
    output logic          busy_o,
    output logic          done_o
);
    import cnn_pkg::*;

    localparam int KK = K * K;
`ifdef CONV_SEQ_PAD_EN
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
    localparam int HALF  = K / 2;
`else
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int HALF  = 0;
`endif
    localparam int NUM_POS = OUT_W * OUT_H;
    localparam int XW      = clogMin1(OUT_W);
    localparam int YW      = clogMin1(OUT_H);
    localparam int KW      = clogMin1(K);
    localparam int TW      = clogMin1(KK);

    localparam logic [AW-1:0] PIX_LAST  = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] POS_LAST  = AW'(NUM_POS - 1);
    localparam logic [TW-1:0] TAP_LAST  = TW'(KK - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(NUM_FILTERS - 1);
    localparam logic [XW-1:0] OX_LAST   = XW'(OUT_W - 1);
    localparam logic [KW-1:0] KX_LAST   = KW'(K - 1);

    seqState_e     state_q;
    logic [AW-1:0] pix_wr_addr_q;
    logic [AW-1:0] pos_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic [FW-1:0] filt_q;
    logic [TW-1:0] tap_q;
    logic [KW-1:0] kx_q;
    logic [KW-1:0] ky_q;
    logic [WW-1:0] wt_q;

    logic          pix_ready_q;
    logic          tap_valid_q;
    logic [AW-1:0] rd_addr_q;
    logic [WW-1:0] wt_addr_q;
    logic          tap_pad_q;
    logic          acc_clr_q;
    logic          acc_last_q;
    logic [FW-1:0] filt_idx_q;
    logic [AW-1:0] pos_idx_q;
    logic          busy_q;
    logic          done_q;

    logic [AW-1:0] genRdAddr;
    logic          genPad;

    conv_tap_addr_gen #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .XW   (XW),
        .YW   (YW),
        .KW   (KW),
        .HALF (HALF)
    ) u_addrGen (
        .ox_i     (ox_q),
        .oy_i     (oy_q),
        .kx_i     (kx_q),
        .ky_i     (ky_q),
        .rd_addr_o(genRdAddr),
        .tap_pad_o(genPad)
    );

    assign pix_wr_en_o = pix_valid_i & pix_ready_q;

    // Counters nest tap -> filter -> position; tap outputs are registered from
    // the counter values, so each issued tap appears one cycle after it is chosen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pix_wr_addr_q <= '0;
            pos_q         <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            filt_q        <= '0;
            tap_q         <= '0;
            kx_q          <= '0;
            ky_q          <= '0;
            wt_q          <= '0;
            pix_ready_q   <= 1'b0;
            tap_valid_q   <= 1'b0;
            rd_addr_q     <= '0;
            wt_addr_q     <= '0;
            tap_pad_q     <= 1'b0;
            acc_clr_q     <= 1'b0;
            acc_last_q    <= 1'b0;
            filt_idx_q    <= '0;
            pos_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= LOAD;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (pix_wr_en_o) begin
                        if (pix_wr_addr_q == PIX_LAST) begin
                            pix_wr_addr_q <= '0;
                            pix_ready_q   <= 1'b0;
                            state_q       <= COMPUTE;
                        end else begin
                            pix_wr_addr_q <= pix_wr_addr_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (stall_i) begin
                        tap_valid_q <= 1'b0;
                    end else begin
                        tap_valid_q <= 1'b1;
                        rd_addr_q   <= genRdAddr;
                        tap_pad_q   <= genPad;
                        wt_addr_q   <= wt_q;
                        acc_clr_q   <= (tap_q == '0);
                        acc_last_q  <= (tap_q == TAP_LAST);
                        filt_idx_q  <= filt_q;
                        pos_idx_q   <= pos_q;
                        if (tap_q == TAP_LAST) begin
                            tap_q <= '0;
                            kx_q  <= '0;
                            ky_q  <= '0;
                            if (filt_q == FILT_LAST) begin
                                filt_q <= '0;
                                wt_q   <= '0;
                                if (pos_q == POS_LAST) begin
                                    pos_q   <= '0;
                                    ox_q    <= '0;
                                    oy_q    <= '0;
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    pos_q <= pos_q + 1'b1;
                                    if (ox_q == OX_LAST) begin
                                        ox_q <= '0;
                                        oy_q <= oy_q + 1'b1;
                                    end else begin
                                        ox_q <= ox_q + 1'b1;
                                    end
                                end
                            end else begin
                                filt_q <= filt_q + 1'b1;
                                wt_q   <= wt_q + 1'b1;
                            end
                        end else begin
                            tap_q <= tap_q + 1'b1;
                            wt_q  <= wt_q + 1'b1;
                            if (kx_q == KX_LAST) begin
                                kx_q <= '0;
                                ky_q <= ky_q + 1'b1;
                            end else begin
                                kx_q <= kx_q + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    tap_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_ready_o   = pix_ready_q;
    assign pix_wr_addr_o = pix_wr_addr_q;
    assign tap_valid_o   = tap_valid_q;
    assign rd_addr_o     = rd_addr_q;
    assign wt_addr_o     = wt_addr_q;
    assign tap_pad_o     = tap_pad_q;
    assign acc_clr_o     = acc_clr_q;
    assign acc_last_o    = acc_last_q;
    assign filt_idx_o    = filt_idx_q;
    assign pos_idx_o     = pos_idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
